// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Instruction prefetch queue sequencer and single 8-bit bus arbiter.
// Revision : 1.0
// ============================================================================
module fetch_sequencer #(
    parameter int          DEPTH    = 16,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    mem_req,
    output logic [15:0]             mem_addr,
    output logic                    mem_we,
    output logic [7:0]              mem_wdata,
    input  logic                    mem_ack,
    input  logic [7:0]              mem_rdata,
    input  logic                    data_req,
    input  logic [15:0]             data_addr,
    input  logic                    data_we,
    input  logic [7:0]              data_wdata,
    output logic                    data_ack,
    output logic [7:0]              data_rdata,
    output logic [7:0]              q_byte0,
    output logic [7:0]              q_byte1,
    output logic [7:0]              q_byte2,
    output logic [$clog2(DEPTH):0]  q_count,
    output logic [15:0]             q_pc,
    input  logic [1:0]              consume,
    input  logic                    redirect,
    input  logic [15:0]             redirect_pc
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_DROP  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_mem_req;
    logic [15:0]      r_mem_addr;
    logic             r_mem_we;
    logic [7:0]       r_mem_wdata;
    logic [7:0]       r_queue [DEPTH];
    logic [c_AW-1:0]  r_head;
    logic [c_AW-1:0]  r_tail;
    logic [c_AW:0]    r_count;
    logic [15:0]      r_q_pc;
    logic [15:0]      r_fetch_pc;

    logic             w_full;
    logic             w_issue_data;
    logic             w_issue_fetch;
    logic             w_push;
    logic             w_bus_done;
    logic [1:0]       w_take;
    logic [c_AW-1:0]  w_idx1;
    logic [c_AW-1:0]  w_idx2;

    assign w_full = (r_count == c_FULL);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: data has fixed priority, an in-flight fetch is never preempted
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (data_req) begin
                    w_state_next = c_DATA;
                end else if (!w_full && !redirect) begin
                    w_state_next = c_FETCH;
                end
            end
            c_FETCH: begin
                if (mem_ack) begin
                    w_state_next = c_IDLE;
                end else if (redirect) begin
                    w_state_next = c_DROP;
                end
            end
            c_DATA, c_DROP: begin
                if (mem_ack) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_issue_data  = (r_state == c_IDLE) && data_req;
        w_issue_fetch = (r_state == c_IDLE) && !data_req && !w_full && !redirect;
        w_push        = (r_state == c_FETCH) && mem_ack && !redirect;
        w_bus_done    = (r_state != c_IDLE) && mem_ack;
        data_ack      = (r_state == c_DATA) && mem_ack;
        data_rdata    = data_ack ? mem_rdata : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 8'h00;
        end else if (w_issue_data) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= data_addr;
            r_mem_we    <= data_we;
            r_mem_wdata <= data_wdata;
        end else if (w_issue_fetch) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= r_fetch_pc;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 8'h00;
        end else if (w_bus_done) begin
            r_mem_req   <= 1'b0;
        end
    end

    // Consuming more than is held simply empties the queue
    assign w_take = ((c_AW + 1)'(consume) > r_count) ? r_count[1:0] : consume;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_q_pc     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else if (redirect) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_q_pc     <= redirect_pc;
            r_fetch_pc <= redirect_pc;
        end else begin
            r_head  <= r_head + c_AW'(w_take);
            r_q_pc  <= r_q_pc + 16'(w_take);
            r_count <= r_count + (c_AW + 1)'(w_push) - (c_AW + 1)'(w_take);
            if (w_push) begin
                r_tail     <= r_tail + c_AW'(1);
                r_fetch_pc <= r_fetch_pc + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_queue[r_tail] <= mem_rdata;
        end
    end

    assign w_idx1 = r_head + c_AW'(1);
    assign w_idx2 = r_head + c_AW'(2);

    assign q_byte0   = (r_count > (c_AW + 1)'(0)) ? r_queue[r_head] : 8'h00;
    assign q_byte1   = (r_count > (c_AW + 1)'(1)) ? r_queue[w_idx1] : 8'h00;
    assign q_byte2   = (r_count > (c_AW + 1)'(2)) ? r_queue[w_idx2] : 8'h00;
    assign q_count   = r_count;
    assign q_pc      = r_q_pc;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
